// File: rtl/dma_addr_gen_mc.sv
// dma_addr_gen_mc: multi-channel DMA address / word-count generator.
// Each channel has an address and word counter set that the host programs.
// Peripheral requests are arbitrated round-robin, and each transfer is
// presented to the peripheral with a valid/ack handshake.
module dma_addr_gen_mc #(
   parameter int unsigned W   = 8,
   parameter int unsigned NCH = 4,
   parameter int unsigned CHW = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           instr_v,
   input  logic [2:0]     instr,
   input  logic [CHW-1:0] ch_sel,
   input  logic [W-1:0]   datain,
   output logic [W-1:0]   dataout,
   output logic           oedata,
   input  logic [NCH-1:0] req,
   output logic [NCH-1:0] gnt,
   output logic [W-1:0]   address,
   output logic           valid,
   input  logic           xfer_ack,
   output logic [NCH-1:0] done,
   output logic           irq
);

   localparam logic [2:0] I_WRCR   = 3'd0;
   localparam logic [2:0] I_RDCR   = 3'd1;
   localparam logic [2:0] I_RDWC   = 3'd2;
   localparam logic [2:0] I_RDAC   = 3'd3;
   localparam logic [2:0] I_REINIT = 3'd4;
   localparam logic [2:0] I_LDAR   = 3'd5;
   localparam logic [2:0] I_LDWR   = 3'd6;
   localparam logic [2:0] I_EN     = 3'd7;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   ar [NCH];
   logic [W-1:0]   wr [NCH];
   logic [W-1:0]   ac [NCH];
   logic [W-1:0]   wc [NCH];
   logic [3:0]     cr [NCH];
   logic [NCH-1:0] run;
   logic [CHW-1:0] ptr, cur, pick;
   logic [NCH-1:0] elig;
   logic           found, start, ack_step, step_en, stp_done;
   logic [1:0]     cur_mode;
   logic [W-1:0]   ac_stp, wc_stp;

   // Word-counter value loaded on (re)initialisation: WR in counting modes, else 0.
   function automatic logic [W-1:0] wc_init(input logic [3:0] c, input logic [W-1:0] w);
      return (c[1:0] == 2'd0 || c[1:0] == 2'd3) ? w : '0;
   endfunction

   assign irq = |done;

   // Host read path: combinational readback of the selected channel.
   always_comb begin
      dataout = '0;
      oedata  = 1'b0;
      if (instr_v) begin
         case (instr)
            I_RDCR:  begin oedata = 1'b1; dataout = W'(cr[ch_sel]); end
            I_RDWC:  begin oedata = 1'b1; dataout = wc[ch_sel]; end
            I_RDAC:  begin oedata = 1'b1; dataout = ac[ch_sel]; end
            default: ;
         endcase
      end
   end

   // Eligibility and round-robin pick, starting just after the pointer.
   always_comb begin
      int unsigned j;
      j     = 0;
      found = 1'b0;
      pick  = '0;
      for (int unsigned i = 0; i < NCH; i++)
         elig[i] = run[i] & req[i] & ~(cr[i][1:0] == 2'd0 && wc[i] == '0);
      for (int unsigned k = 1; k <= NCH; k++) begin
         j = 32'(ptr) + k;
         if (j >= NCH) j = j - NCH;
         if (!found && elig[CHW'(j)]) begin
            found = 1'b1;
            pick  = CHW'(j);
         end
      end
   end

   // Next-state logic for the transfer handshake FSM.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      ack_step  = 1'b0;
      case (state)
         IDLE: if (found) begin
            state_nxt = BUSY;
            start     = 1'b1;
         end
         BUSY: if (xfer_ack) begin
            state_nxt = IDLE;
            ack_step  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counter step for the granted channel; a host instruction on it wins.
   always_comb begin
      cur_mode = cr[cur][1:0];
      ac_stp   = cr[cur][2] ? ac[cur] - W'(1) : ac[cur] + W'(1);
      wc_stp   = wc[cur];
      stp_done = 1'b0;
      case (cur_mode)
         2'd0: begin wc_stp = wc[cur] - W'(1); stp_done = (wc[cur] == W'(1)); end
         2'd1: begin wc_stp = wc[cur] + W'(1); stp_done = (wc_stp == wr[cur]); end
         2'd2: stp_done = (ac_stp == wr[cur]);
         default: begin wc_stp = wc[cur] - W'(1); stp_done = (wc[cur] == '0); end
      endcase
      step_en = ack_step && !(instr_v && ch_sel == cur);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Handshake outputs, granted channel and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid   <= 1'b0;
         gnt     <= '0;
         address <= '0;
         cur     <= '0;
         ptr     <= CHW'(NCH - 1);
      end else if (start) begin
         valid   <= 1'b1;
         gnt     <= NCH'(1) << pick;
         address <= ac[pick];
         cur     <= pick;
      end else if (ack_step) begin
         valid   <= 1'b0;
         gnt     <= '0;
         ptr     <= cur;
      end
   end

   // Per-channel registers: host instructions, then transfer steps.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            ar[i] <= '0;
            wr[i] <= '0;
            ac[i] <= '0;
            wc[i] <= '0;
            cr[i] <= '0;
         end
         run  <= '0;
         done <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (instr_v && ch_sel == CHW'(i)) begin
               case (instr)
                  I_WRCR:   begin cr[i] <= datain[3:0]; run[i] <= 1'b0; end
                  I_REINIT: begin ac[i] <= ar[i]; wc[i] <= wc_init(cr[i], wr[i]); done[i] <= 1'b0; end
                  I_LDAR:   begin ar[i] <= datain; ac[i] <= datain; end
                  I_LDWR:   begin wr[i] <= datain; wc[i] <= wc_init(cr[i], datain); done[i] <= 1'b0; end
                  I_EN:     run[i] <= 1'b1;
                  default:  ;
               endcase
            end else if (step_en && cur == CHW'(i)) begin
               if (stp_done) begin
                  done[i] <= 1'b1;
                  if (cr[i][3]) begin
                     ac[i] <= ar[i];
                     wc[i] <= wc_init(cr[i], wr[i]);
                  end else begin
                     ac[i]  <= ac_stp;
                     wc[i]  <= wc_stp;
                     run[i] <= 1'b0;
                  end
               end else begin
                  ac[i] <= ac_stp;
                  wc[i] <= wc_stp;
               end
            end
         end
      end
   end

endmodule
